axi_hgate_mc_wrapper: RTL and testbench
=======================================

# axi_hgate_mc_wrapper

AXI4-Lite slave that fronts `NUM_CH` independent H-Gate cores behind one bus port and generalises the single-channel wrapper. It adds:
- a per-channel address window map;
- independent AW/W acceptance;
- SLVERR responses;
- busy-write protection;
- a wrapper control window with a per-channel W1C interrupt status register, an interrupt enable register and a level IRQ.

It sits between the SoC interconnect and the H-Gate core array.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: bus data width. Only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 12: bus address width. Must be at least 8 + clog2(`NUM_CH`+1).
- `NUM_CH`, 4: number of H-Gate channels, 1..8.
- `S_AXI_ACLK`  in  1  single clock. All logic runs on its rising edge.
- `S_AXI_ARESET`  in  1  reset, synchronous, active-high.
- `S_AXI_AWADDR`/`AWVALID`/`AWREADY`  in/in/out  `C_S_AXI_ADDR_WIDTH`/1/1  write address channel.
- `S_AXI_WDATA`/`WSTRB`/`WVALID`/`WREADY`  in/in/in/out  32/4/1/1  write data channel.
- `S_AXI_BRESP`/`BVALID`/`BREADY`  out/out/in  2/1/1  write response channel.
- `S_AXI_ARADDR`/`ARVALID`/`ARREADY`  in/in/out  `C_S_AXI_ADDR_WIDTH`/1/1  read address channel.
- `S_AXI_RDATA`/`RRESP`/`RVALID`/`RREADY`  out/out/out/in  32/2/1/1  read data channel.
- `CH_WE`  out  `NUM_CH`  one-hot write strobe per core. High for exactly one cycle per write.
- `CH_WADDR`  out  8  core write offset. Valid while `CH_WE` is non-zero.
- `CH_WDATA`  out  32  core write data. Valid while `CH_WE` is non-zero.
- `CH_RADDR`  out  8  core read offset.
- `CH_RDATA`  in  32*`NUM_CH`  core read data. Channel k occupies bits [32k+31:32k]. Cores drive it combinationally from `CH_RADDR`.
- `CH_BUSY`  in  `NUM_CH`  per-core busy flag.
- `IRQ`  out  1  level interrupt, equal to the OR of (STATUS & ENABLE).

## Operation
- Address decode:
  - the window is `addr[C_S_AXI_ADDR_WIDTH-1:8]` and the offset is `addr[7:0]`;
  - windows 0..`NUM_CH`-1 select the cores;
  - window `NUM_CH` is the control window;
  - any other window decodes to SLVERR (2'b10).
- Control window registers:
  - 0x00 STATUS: W1C, `NUM_CH` bits.
  - 0x04 ENABLE: RW.
  - 0x08 BUSY: RO mirror of `CH_BUSY`.
  - 0x0C INFO: RO, fixed value {24'h484701, `NUM_CH`[7:0]}.
  - Other offsets: SLVERR.
  - Writes to BUSY or INFO: SLVERR, no effect.
  - Unused upper bits read 0.
- Write path:
  - AW and W each have a one-entry holding register. Each is accepted independently, in either order.
  - `AWREADY` is !aw_full and `WREADY` is !w_full, both registered.
  - A write issues when both holding registers are full and `BVALID`=0.
- Write issue rules, in priority order:
  1. Decode error: SLVERR, nothing is written.
  2. `WSTRB` not equal to 4'hF: SLVERR, nothing is written.
  3. Core window with `CH_BUSY[k]`=1: SLVERR, the write is dropped (busy protection).
  4. Otherwise: core window pulses `CH_WE[k]`; control window updates the register. Response OKAY.
- Read path:
  - AR holding register. `ARREADY` is !ar_full & !`RVALID`.
  - `CH_RADDR` is the latched offset.
  - `RDATA` is captured from the selected channel's `CH_RDATA` slice, or from the control register.
  - Decode error: `RDATA`=0, `RRESP`=SLVERR.
  - Reads never check busy.
- Interrupt:
  - busy_d is registered `CH_BUSY`.
  - A falling edge on bit k (busy_d[k] & !`CH_BUSY`[k]) sets STATUS[k].
  - A W1C write clears the bits written as 1.
  - Set and clear in the same cycle: set wins.
  - `IRQ` is combinational from STATUS and ENABLE registers only.

## Timing
- Reset (`S_AXI_ARESET`=1 at a rising edge):
  - All holding registers are empty, STATUS=0, ENABLE=0, busy_d=0.
  - `AWREADY`, `WREADY`, `ARREADY`, `BVALID`, `RVALID` = 0.
  - `BRESP`, `RRESP`, `RDATA`, `CH_WE`, `CH_WADDR`, `CH_WDATA`, `CH_RADDR`, `IRQ` = 0.
  - The ready outputs rise in the first cycle after reset deasserts.
- Reset mid-transaction: pending AW/W/AR data and any pending B/R response are discarded without a response. No `CH_WE` pulse occurs in the reset cycle.
- Write, with the AW and W handshakes completing at edge E0:
  - the cycle after E0: `CH_WE` high for one cycle;
  - `BVALID` rises at E1 with the final `BRESP`;
  - the holding registers clear at E1;
  - `AWREADY` and `WREADY` re-assert after E1.
- Split AW/W: issue happens the cycle after the later of the two handshakes.
- Back-pressure:
  - While `BVALID`=1 and `BREADY`=0, a new AW/W pair may be latched but does not issue.
  - It issues in the cycle after the B handshake.
  - Latency from the later of the AW/W handshakes to `BVALID` is 2 edges minimum.
- Read, with the AR handshake at E0:
  - `CH_RADDR` is valid after E0;
  - `RDATA` is sampled and `RVALID` rises at E1;
  - `RDATA` and `RRESP` are held stable until the R handshake.
- STATUS set: the edge after `CH_BUSY` falls. `IRQ` follows in the same cycle STATUS changes.

## Test plan
- Write one channel: AW=0x104 and W=0xDEADBEEF with `WSTRB`=F, issued together, `NUM_CH`=4, `CH_BUSY`=0.
  Required: `CH_WE`=4'b0010 for one cycle with `CH_WADDR`=0x04 and `CH_WDATA`=0xDEADBEEF; then `BVALID` with `BRESP`=00.
- Read one channel: `CH_RDATA` slice 2 = 0x12345678; read 0x210.
  Required: `CH_RADDR`=0x10; `RDATA`=0x12345678, `RRESP`=00, `RVALID` at E1. Then read 0x500: `RDATA`=0, `RRESP`=10.
- Error writes: write 0x0FF to channel 0 while `CH_BUSY[0]`=1.
  Required: no `CH_WE`, `BRESP`=10. Then `WSTRB`=4'h3 with channel idle: `BRESP`=10, no `CH_WE`.
- Interrupt flow: ENABLE=4'b0100 written at 0x404; pulse `CH_BUSY[2]` high for 3 cycles, then low.
  Required: STATUS=4'b0100 and `IRQ`=1 one edge after the fall. Writing 0x4 to 0x400 clears STATUS and drops `IRQ`. A fall coincident with the W1C write leaves STATUS[2]=1.
- Ordering and back-pressure: W sent 3 cycles before AW, with `BREADY` held low for 5 cycles.
  Required: a single `CH_WE` pulse the cycle after the AW handshake. `BVALID` and `BRESP` stay stable until `BREADY`. A second AW/W pair latches but issues only after the B handshake.
- Reset mid-transaction: assert `S_AXI_ARESET` while `RVALID`=1 and again while `BVALID`=1.
  Required: all outputs at reset values the cycle after. No stale response after deassert. INFO read returns 0x48470104.

Source files
------------

// File: rtl/axi_hgate_mc_wrapper.sv
// AXI4-Lite slave fronting NUM_CH H-Gate cores: per-channel address windows,
// independent AW/W holding registers, busy-write protection and a W1C IRQ block.
module axi_hgate_mc_wrapper #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int NUM_CH             = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_CH-1:0]                 CH_WE,
  output logic [7:0]                        CH_WADDR,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     CH_WDATA,
  output logic [7:0]                        CH_RADDR,
  input  logic [C_S_AXI_DATA_WIDTH*NUM_CH-1:0] CH_RDATA,
  input  logic [NUM_CH-1:0]                 CH_BUSY,
  output logic                              IRQ
);

  localparam int                 WIN_W    = C_S_AXI_ADDR_WIDTH - 8;
  localparam logic [WIN_W-1:0]   CTRL_WIN = WIN_W'(NUM_CH);
  localparam logic [1:0]         SLVERR   = 2'b10;

  logic                          aw_full_p0, w_full_p0, ar_full_p0;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_p0, ar_addr_p0;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_p0;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb_p0;
  logic                          awready_q, wready_q, arready_q, bvalid_p1, rvalid_p1;
  logic [1:0]                    bresp_p1, rresp_p1;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_p1;
  logic [NUM_CH-1:0]             status_q, enable_q, busy_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, issue, rd_go;
  logic aw_full_nxt, w_full_nxt, ar_full_nxt, bvalid_nxt, rvalid_nxt;

  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID  & wready_q;
  assign ar_hs = S_AXI_ARVALID & arready_q;
  assign b_hs  = bvalid_p1 & S_AXI_BREADY;
  assign r_hs  = rvalid_p1 & S_AXI_RREADY;
  // Reset gates issue so no core strobe escapes in the reset cycle.
  assign issue = aw_full_p0 & w_full_p0 & ~bvalid_p1 & ~S_AXI_ARESET;
  assign rd_go = ar_full_p0 & ~rvalid_p1;

  assign aw_full_nxt = (aw_full_p0 & ~issue) | aw_hs;
  assign w_full_nxt  = (w_full_p0  & ~issue) | w_hs;
  assign ar_full_nxt = (ar_full_p0 & ~rd_go) | ar_hs;
  assign bvalid_nxt  = (bvalid_p1 & ~b_hs) | issue;
  assign rvalid_nxt  = (rvalid_p1 & ~r_hs) | rd_go;

  logic [WIN_W-1:0]  w_win, r_win;
  logic [7:0]        w_off, r_off;
  logic [NUM_CH-1:0] w_sel, sts_clr;
  logic              w_core, w_ctrl, w_busy, w_err, en_wr;

  assign w_win  = aw_addr_p0[C_S_AXI_ADDR_WIDTH-1:8];
  assign w_off  = aw_addr_p0[7:0];
  assign w_ctrl = (w_win == CTRL_WIN);

  always_comb begin
    w_core = 1'b0;
    w_sel  = '0;
    w_busy = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_win == WIN_W'(k)) begin
        w_core   = 1'b1;
        w_sel[k] = 1'b1;
        w_busy   = CH_BUSY[k];
      end
    end
    w_err = 1'b0;
    if (!w_core && !w_ctrl)                   w_err = 1'b1;
    else if (w_strb_p0 != '1)                 w_err = 1'b1;
    else if (w_core && w_busy)                w_err = 1'b1;
    else if (w_ctrl && w_off != 8'h00 && w_off != 8'h04) w_err = 1'b1;
  end

  assign CH_WE    = (issue && !w_err && w_core) ? w_sel : '0;
  assign CH_WADDR = issue ? w_off : '0;
  assign CH_WDATA = issue ? w_data_p0 : '0;
  assign sts_clr  = (issue && !w_err && w_ctrl && w_off == 8'h00) ? w_data_p0[NUM_CH-1:0] : '0;
  assign en_wr    = issue && !w_err && w_ctrl && (w_off == 8'h04);

  logic [C_S_AXI_DATA_WIDTH-1:0] r_data;
  logic                          r_err;

  assign r_win = ar_addr_p0[C_S_AXI_ADDR_WIDTH-1:8];
  assign r_off = ar_addr_p0[7:0];

  always_comb begin
    r_data = '0;
    r_err  = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_win == WIN_W'(k)) begin
        r_data = CH_RDATA[C_S_AXI_DATA_WIDTH*k +: C_S_AXI_DATA_WIDTH];
        r_err  = 1'b0;
      end
    end
    if (r_win == CTRL_WIN) begin
      case (r_off)
        8'h00:   begin r_data = C_S_AXI_DATA_WIDTH'(status_q); r_err = 1'b0; end
        8'h04:   begin r_data = C_S_AXI_DATA_WIDTH'(enable_q); r_err = 1'b0; end
        8'h08:   begin r_data = C_S_AXI_DATA_WIDTH'(CH_BUSY);  r_err = 1'b0; end
        8'h0C:   begin r_data = {24'h484701, 8'(NUM_CH)};      r_err = 1'b0; end
        default: r_data = '0;
      endcase
    end
  end

  // Stage p0: holding registers; stage p1: B/R responses and control state.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_full_p0 <= 1'b0;
      w_full_p0  <= 1'b0;
      ar_full_p0 <= 1'b0;
      ar_addr_p0 <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      bvalid_p1  <= 1'b0;
      rvalid_p1  <= 1'b0;
      bresp_p1   <= 2'b00;
      rresp_p1   <= 2'b00;
      rdata_p1   <= '0;
      status_q   <= '0;
      enable_q   <= '0;
      busy_d     <= '0;
    end else begin
      aw_full_p0 <= aw_full_nxt;
      w_full_p0  <= w_full_nxt;
      ar_full_p0 <= ar_full_nxt;
      awready_q  <= ~aw_full_nxt;
      wready_q   <= ~w_full_nxt;
      arready_q  <= ~ar_full_nxt & ~rvalid_nxt;
      bvalid_p1  <= bvalid_nxt;
      rvalid_p1  <= rvalid_nxt;
      busy_d     <= CH_BUSY;
      status_q   <= (status_q & ~sts_clr) | (busy_d & ~CH_BUSY);
      if (ar_hs) ar_addr_p0 <= S_AXI_ARADDR;
      if (issue) bresp_p1 <= w_err ? SLVERR : 2'b00;
      if (en_wr) enable_q <= w_data_p0[NUM_CH-1:0];
      if (rd_go) begin
        rdata_p1 <= r_err ? '0 : r_data;
        rresp_p1 <= r_err ? SLVERR : 2'b00;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (aw_hs) aw_addr_p0 <= S_AXI_AWADDR;
    if (w_hs) begin
      w_data_p0 <= S_AXI_WDATA;
      w_strb_p0 <= S_AXI_WSTRB;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_BVALID  = bvalid_p1;
  assign S_AXI_BRESP   = bresp_p1;
  assign S_AXI_RVALID  = rvalid_p1;
  assign S_AXI_RRESP   = rresp_p1;
  assign S_AXI_RDATA   = rdata_p1;
  assign CH_RADDR      = ar_addr_p0[7:0];
  assign IRQ           = |(status_q & enable_q);

endmodule

// File: tb/tb_axi_hgate_mc_wrapper.sv
// Directed bench for axi_hgate_mc_wrapper: vector table plus timing sequences
// for write/read latency, interrupts, back-pressure and mid-transaction reset.
module tb_axi_hgate_mc_wrapper;
  localparam int NUM_CH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [11:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, ch_wdata;
  logic [3:0] wstrb, ch_we, ch_busy;
  logic [1:0] bresp, rresp;
  logic [7:0] ch_waddr, ch_raddr;
  logic [127:0] ch_rdata;
  logic irq;
  logic [31:0] base [NUM_CH];

  axi_hgate_mc_wrapper #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(12), .NUM_CH(NUM_CH)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .CH_WE(ch_we), .CH_WADDR(ch_waddr), .CH_WDATA(ch_wdata), .CH_RADDR(ch_raddr),
    .CH_RDATA(ch_rdata), .CH_BUSY(ch_busy), .IRQ(irq)
  );

  // Core model: each slice answers base[k] XOR the read offset.
  always_comb begin
    ch_rdata = '0;
    for (int k = 0; k < NUM_CH; k++) ch_rdata[32*k +: 32] = base[k] ^ {24'h0, ch_raddr};
  end

  int we_cnt = 0;
  logic [3:0]  last_we;
  logic [7:0]  last_waddr;
  logic [31:0] last_wdata;
  always @(negedge clk) begin
    if (ch_we != 4'b0) begin
      we_cnt     <= we_cnt + 1;
      last_we    <= ch_we;
      last_waddr <= ch_waddr;
      last_wdata <= ch_wdata;
    end
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    n_tot++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] outs();
    return 128'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata,
                 ch_we, ch_waddr, ch_wdata, ch_raddr, irq});
  endfunction

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done, w_done, hs_aw, hs_w, got;
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin wvalid  = 1'b0; w_done  = 1'b1; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) tmo("aw_w_handshake");
    got = 1'b0; n = 0; resp = 2'bxx;
    while (!got && n < 50) begin
      @(negedge clk);
      if (bvalid) begin resp = bresp; got = 1'b1; end
      tick();
      n++;
    end
    bready = 1'b0;
    if (!got) tmo("bvalid_wait");
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit hs, got;
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = arready;
      tick();
      n++;
    end
    arvalid = 1'b0;
    if (!hs) tmo("ar_handshake");
    got = 1'b0; n = 0; d = 'x; resp = 2'bxx;
    while (!got && n < 50) begin
      @(negedge clk);
      if (rvalid) begin d = rdata; resp = rresp; got = 1'b1; end
      tick();
      n++;
    end
    rready = 1'b0;
    if (!got) tmo("rvalid_wait");
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  busy;
    logic [1:0]  resp;
    logic [3:0]  we;
    logic [31:0] rdat;
  } vec_t;
  vec_t vecs[$];

  task automatic wv(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [3:0] b, input logic [1:0] r, input logic [3:0] we);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.data = d; v.strb = s; v.busy = b; v.resp = r; v.we = we; v.rdat = '0;
    vecs.push_back(v);
  endtask

  task automatic rv(input logic [11:0] a, input logic [3:0] b, input logic [31:0] d,
                    input logic [1:0] r);
    vec_t v;
    v.wr = 1'b0; v.addr = a; v.data = '0; v.strb = '0; v.busy = b; v.resp = r; v.we = '0; v.rdat = d;
    vecs.push_back(v);
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int we0;

    rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0; ch_busy = '0;
    base[0] = 32'hA000_0000; base[1] = 32'hB100_0000;
    base[2] = 32'h1234_5668; base[3] = 32'hD300_0000;

    wv(12'h104, 32'hDEAD_BEEF, 4'hF, 4'b0000, 2'b00, 4'b0010);
    wv(12'h3FC, 32'h0000_1111, 4'hF, 4'b0000, 2'b00, 4'b1000);
    rv(12'h210, 4'b0000, 32'h1234_5678, 2'b00);
    rv(12'h00C, 4'b0000, 32'hA000_000C, 2'b00);
    rv(12'h3F0, 4'b0000, 32'hD300_00F0, 2'b00);
    rv(12'h500, 4'b0000, 32'h0,         2'b10);
    rv(12'hF00, 4'b0000, 32'h0,         2'b10);
    wv(12'h500, 32'h1,         4'hF, 4'b0000, 2'b10, 4'b0000);
    wv(12'h0FF, 32'h5,         4'hF, 4'b0001, 2'b10, 4'b0000);
    wv(12'h0FF, 32'h5,         4'h3, 4'b0000, 2'b10, 4'b0000);
    rv(12'h40C, 4'b0000, 32'h4847_0104, 2'b00);
    rv(12'h408, 4'b0101, 32'h0000_0005, 2'b00);
    wv(12'h404, 32'h0000_000A, 4'hF, 4'b0000, 2'b00, 4'b0000);
    rv(12'h404, 4'b0000, 32'h0000_000A, 2'b00);
    wv(12'h408, 32'h1,         4'hF, 4'b0000, 2'b10, 4'b0000);
    wv(12'h40C, 32'h1,         4'hF, 4'b0000, 2'b10, 4'b0000);
    wv(12'h410, 32'h1,         4'hF, 4'b0000, 2'b10, 4'b0000);
    rv(12'h410, 4'b0000, 32'h0,         2'b10);
    wv(12'h204, 32'h1,         4'hF, 4'b0100, 2'b10, 4'b0000);
    rv(12'h204, 4'b0100, 32'h1234_566C, 2'b00);
    wv(12'h204, 32'hCAFE_0001, 4'hF, 4'b1011, 2'b00, 4'b0100);

    // Reset state
    repeat (3) tick();
    chk("reset_outputs", outs(), 128'h0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 128'({awready, wready, arready}), 128'(3'b111));

    // Vector table
    foreach (vecs[i]) begin
      ch_busy = vecs[i].busy;
      tick();
      we0 = we_cnt;
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), 128'(r), 128'(vecs[i].resp));
        chk($sformatf("vec%0d_we_count", i), 128'(we_cnt - we0), 128'(vecs[i].we != 4'b0));
        if (vecs[i].we != 4'b0) begin
          chk($sformatf("vec%0d_we", i), 128'(last_we), 128'(vecs[i].we));
          chk($sformatf("vec%0d_waddr", i), 128'(last_waddr), 128'(vecs[i].addr[7:0]));
          chk($sformatf("vec%0d_wdata", i), 128'(last_wdata), 128'(vecs[i].data));
        end
      end else begin
        axi_read(vecs[i].addr, d, r);
        chk($sformatf("vec%0d_rdata", i), 128'(d), 128'(vecs[i].rdat));
        chk($sformatf("vec%0d_rresp", i), 128'(r), 128'(vecs[i].resp));
      end
    end
    ch_busy = '0;
    repeat (2) tick();

    // Write latency: AW+W together at E0
    awaddr = 12'h104; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wt_we_after_e0", 128'({ch_we, ch_waddr, ch_wdata}), 128'({4'b0010, 8'h04, 32'hDEAD_BEEF}));
    chk("wt_bvalid_after_e0", 128'({bvalid, awready}), 128'(2'b00));
    tick();
    chk("wt_after_e1", 128'({ch_we, bvalid, bresp, awready, wready}), 128'({4'b0000, 1'b1, 2'b00, 2'b11}));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("wt_b_done", 128'(bvalid), 128'(1'b0));

    // Read latency and hold
    araddr = 12'h210; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    chk("rt_raddr_after_e0", 128'({ch_raddr, rvalid, arready}), 128'({8'h10, 2'b00}));
    tick();
    chk("rt_after_e1", 128'({rvalid, rresp, rdata}), 128'({1'b1, 2'b00, 32'h1234_5678}));
    base[2] = 32'h0;
    repeat (2) tick();
    chk("rt_hold", 128'({rvalid, rresp, rdata}), 128'({1'b1, 2'b00, 32'h1234_5678}));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    base[2] = 32'h1234_5668;
    chk("rt_r_done", 128'(rvalid), 128'(1'b0));

    // Interrupt flow
    axi_write(12'h400, 32'hF, 4'hF, r);
    axi_write(12'h404, 32'h4, 4'hF, r);
    axi_read(12'h400, d, r);
    chk("irq_status_clear", 128'({d, irq}), 128'({32'h0, 1'b0}));
    ch_busy = 4'b0100;
    repeat (3) tick();
    ch_busy = 4'b0000;
    chk("irq_before_edge", 128'(irq), 128'(1'b0));
    tick();
    chk("irq_after_fall", 128'(irq), 128'(1'b1));
    axi_read(12'h400, d, r);
    chk("irq_status_set", 128'(d), 128'(32'h4));
    axi_write(12'h400, 32'h4, 4'hF, r);
    chk("irq_w1c_drop", 128'({irq, r}), 128'({1'b0, 2'b00}));
    ch_busy = 4'b0100;
    repeat (2) tick();
    awaddr = 12'h400; wdata = 32'h4; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; ch_busy = 4'b0000;
    tick();
    chk("irq_set_wins", 128'({bvalid, bresp, irq}), 128'({1'b1, 2'b00, 1'b1}));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(12'h400, d, r);
    chk("irq_set_wins_status", 128'(d), 128'(32'h4));
    axi_write(12'h400, 32'h4, 4'hF, r);
    chk("irq_final_clear", 128'(irq), 128'(1'b0));

    // Ordering and back-pressure
    we0 = we_cnt;
    bready = 1'b0;
    wdata = 32'h55AA_55AA; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    repeat (3) tick();
    chk("bp_no_issue_w_only", 128'(we_cnt - we0), 128'(0));
    awaddr = 12'h30C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("bp_first_issue", 128'({ch_we, ch_waddr, ch_wdata}), 128'({4'b1000, 8'h0C, 32'h55AA_55AA}));
    tick();
    chk("bp_bvalid_rise", 128'({bvalid, bresp}), 128'(3'b100));
    awaddr = 12'h108; wdata = 32'h0000_0077; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk($sformatf("bp_b_stable%0d", i), 128'({bvalid, bresp, ch_we}), 128'({3'b100, 4'b0000}));
    end
    chk("bp_second_latched", 128'({awready, wready, we_cnt - we0}), 128'({2'b00, 32'd1}));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bp_second_issue", 128'({ch_we, ch_waddr, ch_wdata, bvalid}), 128'({4'b0010, 8'h08, 32'h77, 1'b0}));
    tick();
    chk("bp_second_b", 128'({bvalid, bresp, ch_we}), 128'({3'b100, 4'b0000}));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bp_pulse_total", 128'(we_cnt - we0), 128'(2));

    // Reset with RVALID pending
    araddr = 12'h00C; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    tick();
    chk("rst_r_pending", 128'(rvalid), 128'(1'b1));
    rst = 1'b1;
    tick();
    chk("rst_r_outputs", outs(), 128'h0);
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_r_no_stale", 128'({rvalid, bvalid, arready}), 128'(3'b001));

    // Reset with BVALID pending
    awaddr = 12'h004; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("rst_b_pending", 128'(bvalid), 128'(1'b1));
    rst = 1'b1;
    tick();
    chk("rst_b_outputs", outs(), 128'h0);
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_b_no_stale", 128'({bvalid, awready, wready}), 128'(3'b011));

    // Reset landing in the issue cycle
    we0 = we_cnt;
    awaddr = 12'h104; wdata = 32'h9; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
    #1;
    chk("rst_issue_no_we", 128'(ch_we), 128'(4'b0));
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_issue_dropped", 128'({we_cnt - we0, bvalid}), 128'({32'd0, 1'b0}));

    axi_read(12'h40C, d, r);
    chk("info_after_reset", 128'({d, r}), 128'({32'h4847_0104, 2'b00}));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
